// File: rtl/mixer_pkg.sv
// Shared FSM encodings and width helper for the audio mixer MAC.
package mixer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mixer_mac.sv
// Registered unsigned multiply-accumulate: clear has priority over enable.
module mixer_mac #(
   parameter int A_W   = 8,
   parameter int B_W   = 4,
   parameter int ACC_W = 14
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [A_W-1:0]   a_i,
   input  logic [B_W-1:0]   b_i,
   output logic [ACC_W-1:0] acc_o
);

   localparam int PROD_W = A_W + B_W;

   logic [PROD_W-1:0] prod;
   logic [ACC_W-1:0]  acc_q;

   assign prod  = {{B_W{1'b0}}, a_i} * {{A_W{1'b0}}, b_i};
   assign acc_o = acc_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q + {{(ACC_W-PROD_W){1'b0}}, prod};
      end
   end

endmodule

// File: rtl/audio_mixer_mac.sv
// Time-multiplexed N-channel mixer: one channel MAC per clock, saturated output.
//   state    | meaning
//   ST_IDLE  | in_ready high, waiting for a frame
//   ST_ACCUM | accumulating channel idx_q
//   ST_DONE  | register saturated mix, pulse mix_valid
module audio_mixer_mac
   import mixer_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int SAMPLE_W  = 8,
   parameter int GAIN_W    = 4,
   parameter int GAIN_FRAC = 3,
   parameter int OUT_W     = 10
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [N_CH*SAMPLE_W-1:0] samples_in,
   input  logic [N_CH*GAIN_W-1:0]   gains_in,
   input  logic [N_CH-1:0]          mute,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     ovr_clr,
   output logic [OUT_W-1:0]         mix_out,
   output logic                     mix_valid,
   output logic                     clipped,
   output logic                     overrun
);

   localparam int IDX_W  = clog2(N_CH);
   localparam int PROD_W = SAMPLE_W + GAIN_W;
   localparam int ACC_W  = PROD_W + clog2(N_CH);
   localparam logic [OUT_W-1:0] OUT_MAX = '1;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [N_CH*SAMPLE_W-1:0] samples_q;
   logic [N_CH*GAIN_W-1:0]   gains_q;
   logic [N_CH-1:0]          mute_q;
   logic [OUT_W-1:0]         mix_out_q, mix_out_d;
   logic                     mix_valid_q, mix_valid_d;
   logic                     clipped_q, clipped_d;
   logic                     overrun_q, overrun_d;
   logic                     accept, last_ch, acc_clr, acc_en, over_lim;
   logic [SAMPLE_W-1:0]      mac_a;
   logic [GAIN_W-1:0]        mac_b;
   logic [ACC_W-1:0]         acc, acc_shr;

   assign in_ready  = (state_q == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign last_ch   = (idx_q == IDX_W'(N_CH - 1));
   assign acc_shr   = acc >> GAIN_FRAC;
   assign over_lim  = (acc_shr > ACC_W'(OUT_MAX));
   assign mix_out   = mix_out_q;
   assign mix_valid = mix_valid_q;
   assign clipped   = clipped_q;
   assign overrun   = overrun_q;

   // Muted channels feed zero operands so the accumulator still steps once per channel.
   always_comb begin
      mac_a = '0;
      mac_b = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (idx_q == IDX_W'(k) && !mute_q[k]) begin
            mac_a = samples_q[k*SAMPLE_W +: SAMPLE_W];
            mac_b = gains_q[k*GAIN_W +: GAIN_W];
         end
      end
   end

   mixer_mac #(
      .A_W   (SAMPLE_W),
      .B_W   (GAIN_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (acc_clr),
      .en_i   (acc_en),
      .a_i    (mac_a),
      .b_i    (mac_b),
      .acc_o  (acc)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_clr     = 1'b0;
      acc_en      = 1'b0;
      mix_out_d   = mix_out_q;
      mix_valid_d = 1'b0;
      clipped_d   = clipped_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ACCUM;
               idx_d   = '0;
               acc_clr = 1'b1;
            end
         end
         ST_ACCUM: begin
            acc_en = 1'b1;
            idx_d  = idx_q + IDX_W'(1);
            if (last_ch) begin
               state_d = ST_DONE;
               idx_d   = '0;
            end
         end
         ST_DONE: begin
            mix_out_d   = over_lim ? OUT_MAX : acc_shr[OUT_W-1:0];
            clipped_d   = over_lim;
            mix_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new overrun event outranks a simultaneous clear.
   assign overrun_d = (in_valid && !in_ready) ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         mix_out_q   <= '0;
         mix_valid_q <= 1'b0;
         clipped_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mix_out_q   <= mix_out_d;
         mix_valid_q <= mix_valid_d;
         clipped_q   <= clipped_d;
         overrun_q   <= overrun_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         samples_q <= '0;
         gains_q   <= '0;
         mute_q    <= '0;
      end else if (accept) begin
         samples_q <= samples_in;
         gains_q   <= gains_in;
         mute_q    <= mute;
      end
   end

endmodule

// File: tb/tb_audio_mixer_mac.sv
// Scoreboard bench for audio_mixer_mac: expected mixes queued at accept, checked on mix_valid.
module tb_audio_mixer_mac;

   logic        clk;
   logic        resetn;
   logic [31:0] samples_in;
   logic [15:0] gains_in;
   logic [3:0]  mute;
   logic        in_valid;
   logic        in_ready;
   logic        ovr_clr;
   logic [9:0]  mix_out;
   logic        mix_valid;
   logic        clipped;
   logic        overrun;

   typedef struct {
      int mix;
      int clip;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   nmix     = 0;
   int   last_mv  = 0;
   int   hold_val = 0;
   bit   have_last = 0;
   bit   b2b       = 0;

   audio_mixer_mac dut (
      .clk        (clk),
      .resetn     (resetn),
      .samples_in (samples_in),
      .gains_in   (gains_in),
      .mute       (mute),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ovr_clr    (ovr_clr),
      .mix_out    (mix_out),
      .mix_valid  (mix_valid),
      .clipped    (clipped),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] s, input logic [15:0] g, input logic [3:0] m);
      exp_t e;
      int acc;
      int sh;
      acc = 0;
      for (int k = 0; k < 4; k++)
         if (!m[k]) acc += int'(s[k*8 +: 8]) * int'(g[k*4 +: 4]);
      sh = acc / 8;
      e.clip = (sh > 1023) ? 1 : 0;
      e.mix  = (sh > 1023) ? 1023 : sh;
      e.cyc  = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (resetn) begin
         if (mix_valid) begin
            nmix++;
            if (sb.size() == 0) begin
               chk("unexpected_mix_valid", 1, 0);
            end else begin
               cur = sb.pop_front();
               chk("mix_out", int'(mix_out), cur.mix);
               chk("clipped", int'(clipped), cur.clip);
               chk("latency", cyc - cur.cyc, 5);
               if (b2b && have_last) chk("b2b_period", cyc - last_mv, 6);
               last_mv   = cyc;
               hold_val  = cur.mix;
               have_last = 1;
            end
         end else if (b2b && have_last) begin
            chk("mix_hold", int'(mix_out), hold_val);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] s, input logic [15:0] g, input logic [3:0] m);
      exp_t e;
      samples_in = s;
      gains_in   = g;
      mute       = m;
      in_valid   = 1'b1;
      e = model(s, g, m);
      e.cyc = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic send(input logic [31:0] s, input logic [15:0] g, input logic [3:0] m);
      wait_ready();
      drive(s, g, m);
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      samples_in = $urandom;
      gains_in   = 16'($urandom);
      mute       = 4'($urandom);
   endtask

   initial begin
      int n0;
      resetn = 1'b0; samples_in = '0; gains_in = '0; mute = '0;
      in_valid = 1'b0; ovr_clr = 1'b0;
      #2;
      chk("rst_mix_out", int'(mix_out), 0);
      chk("rst_mix_valid", int'(mix_valid), 0);
      chk("rst_clipped", int'(clipped), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      #10 resetn = 1'b1;
      @(posedge clk);
      #1;

      send({8'd40, 8'd30, 8'd20, 8'd10}, 16'h8888, 4'b0000);   // 100
      wait_drain();
      send({4{8'd255}}, 16'hFFFF, 4'b0000);                   // clip 1023
      wait_drain();
      send({4{8'd100}}, 16'h8888, 4'b0101);                   // 200
      send({4{8'd100}}, 16'h8888, 4'b1111);                   // 0
      send({8'd200, 8'd200, 8'd50, 8'd50}, 16'h0808, 4'b0000); // gain 0 acts as mute
      for (int i = 0; i < 4; i++) send($urandom, 16'($urandom), 4'($urandom));
      wait_drain();

      // Overrun: in_valid held 2 extra cycles, then set-vs-clear collision, then clear.
      n0 = nmix;
      wait_ready();
      drive({4{8'd16}}, 16'h8888, 4'b0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("overrun_set", int'(overrun), 1);
      in_valid = 1'b1; ovr_clr = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; ovr_clr = 1'b0;
      chk("overrun_set_wins", int'(overrun), 1);
      wait_drain();
      chk("overrun_one_mix", nmix - n0, 1);
      chk("overrun_hold", int'(overrun), 1);
      ovr_clr = 1'b1;
      @(posedge clk); #1;
      ovr_clr = 1'b0;
      chk("overrun_clr", int'(overrun), 0);

      // Reset during the second ACCUM cycle aborts the frame.
      n0 = nmix;
      send({4{8'd200}}, 16'h8888, 4'b0000);
      @(posedge clk);
      #3 resetn = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("abort_mix_out", int'(mix_out), 0);
      chk("abort_mix_valid", int'(mix_valid), 0);
      chk("abort_clipped", int'(clipped), 0);
      chk("abort_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #3 resetn = 1'b1;
      @(posedge clk); #1;
      send({8'd4, 8'd3, 8'd2, 8'd1}, 16'h8888, 4'b0000);      // 10
      wait_drain();
      chk("abort_mix_count", nmix - n0, 1);

      // Back-to-back frames with in_valid held high.
      b2b = 1; have_last = 0;
      samples_in = $urandom; gains_in = 16'($urandom); mute = 4'($urandom);
      in_valid = 1'b1;
      for (int f = 0; f < 4; f++) begin
         wait_ready();
         drive(samples_in, gains_in, mute);
         @(posedge clk); #1;
         samples_in = $urandom; gains_in = 16'($urandom); mute = 4'($urandom);
      end
      in_valid = 1'b0;
      wait_drain();
      repeat (3) begin @(posedge clk); #1; end
      b2b = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
